tt_sweep_checker: RTL and testbench

Sequential stimulus-and-capture stage that sits around a combinational truth-table block. It drives every input vector of an N-input function in ascending binary order (all-zeros first, MSB = A) and samples the block's 1-bit output. It builds the captured truth table, compares it against an expected table, and reports pass/fail, the mismatch count and the first failing row. It replaces hand-written per-row stimulus for the lab's Tabla blocks.

---
 rtl/tt_sweep_checker.sv | 100 ++++++++++
 tb/tb_tt_sweep_checker.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: sweeps all N_IN-bit input vectors through a truth-table block and checks its output.
// Optional abort port/aborted flag enabled by defining TT_SWEEP_ABORT_EN.
module tt_sweep_checker #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef TT_SWEEP_ABORT_EN
    input  logic                 abort,
    output logic                 aborted,
`endif
    input  logic                 start,
    input  logic [(1<<N_IN)-1:0] expected,
    output logic [N_IN-1:0]      vec_out,
    input  logic                 y_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [(1<<N_IN)-1:0] captured,
    output logic [N_IN-1:0]      first_fail_idx,
    output logic                 first_fail_valid
);
    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FINISH} state_t;
    state_t state, state_nx;
    logic [3:0] settle_cnt;
    logic abt, last_row, miss, settled, go;

    assign busy     = state == HOLD || state == SAMPLE;
    assign done     = state == FINISH;
    assign last_row = &vec_out;
    assign miss     = y_in != expected[vec_out];
    assign settled  = 5'(settle_cnt) + 5'd1 == 5'(SETTLE);
    assign go       = state == IDLE && start;

`ifdef TT_SWEEP_ABORT_EN
    assign abt = abort;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) aborted <= 1'b0;
        else aborted <= go ? 1'b0 : (abt && busy) ? 1'b1 : aborted;
`else
    assign abt = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   state_nx = start ? (SETTLE == 0 ? SAMPLE : HOLD) : IDLE;
            HOLD:   state_nx = settled ? SAMPLE : HOLD;
            SAMPLE: state_nx = last_row ? FINISH : (SETTLE == 0 ? SAMPLE : HOLD);
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abt && busy) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out          <= '0;
            settle_cnt       <= '0;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            captured         <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else if (go) begin
            vec_out          <= '0;
            settle_cnt       <= '0;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            captured         <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
        end else if (abt && busy) begin
            pass <= 1'b0;
        end else if (state == HOLD) begin
            settle_cnt <= settle_cnt + 4'd1;
        end else if (state == SAMPLE) begin
            captured[vec_out] <= y_in;
            if (miss) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
                if (!first_fail_valid) begin
                    first_fail_idx   <= vec_out;
                    first_fail_valid <= 1'b1;
                end
            end
            // the count is updated on this same edge, so fold the current row in
            if (last_row) pass <= !miss && mismatch_cnt == '0;
            else begin
                vec_out    <= vec_out + 1'b1;
                settle_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker: directed sweeps on an N_IN=3/SETTLE=1 and an N_IN=4/SETTLE=0 instance.
module tb_tt_sweep_checker;
    logic clk = 0, rst_n = 0, start3 = 0, start4 = 0, inv3 = 0;
    logic [7:0] exp3 = 8'hE8;
    logic [15:0] exp4 = 16'h0000;
    logic [2:0] vec3, ffi3;
    logic [3:0] vec4, ffi4, mc3;
    logic [4:0] mc4;
    logic [7:0] cap3;
    logic [15:0] cap4;
    logic y3, y4, busy3, done3, pass3, ffv3, busy4, done4, pass4, ffv4;
`ifdef TT_SWEEP_ABORT_EN
    logic abort3 = 0, abort4 = 0, aborted3, aborted4;
`endif
    int tests = 0, fails = 0, done_at, ndone, vec_err;

    always #5 clk = ~clk;
    assign y3 = ((vec3[2] & vec3[1]) | (vec3[2] & vec3[0]) | (vec3[1] & vec3[0])) ^ inv3;
    assign y4 = vec4 == 4'd5 || vec4 == 4'd12;

    tt_sweep_checker #(.N_IN(3), .SETTLE(1)) u3 (
        .clk(clk), .rst_n(rst_n),
`ifdef TT_SWEEP_ABORT_EN
        .abort(abort3), .aborted(aborted3),
`endif
        .start(start3), .expected(exp3), .vec_out(vec3), .y_in(y3),
        .busy(busy3), .done(done3), .pass(pass3), .mismatch_cnt(mc3),
        .captured(cap3), .first_fail_idx(ffi3), .first_fail_valid(ffv3)
    );

    tt_sweep_checker #(.N_IN(4), .SETTLE(0)) u4 (
        .clk(clk), .rst_n(rst_n),
`ifdef TT_SWEEP_ABORT_EN
        .abort(abort4), .aborted(aborted4),
`endif
        .start(start4), .expected(exp4), .vec_out(vec4), .y_in(y4),
        .busy(busy4), .done(done4), .pass(pass4), .mismatch_cnt(mc4),
        .captured(cap4), .first_fail_idx(ffi4), .first_fail_valid(ffv4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One sweep; cycle 1 is the first busy cycle. Optional start re-pulse in cycle restart_at.
    task automatic sweep(input bit w, input int restart_at);
        int s = w ? 0 : 1;
        int rows = w ? 16 : 8;
        done_at = 0;
        ndone = 0;
        vec_err = 0;
        @(negedge clk);
        if (w) start4 = 1; else start3 = 1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start3 = !w && c == restart_at;
            start4 = w && c == restart_at;
            if (w ? done4 : done3) begin
                ndone++;
                if (done_at == 0) done_at = c;
            end
            if (c <= rows * (s + 1) && int'(w ? vec4 : {1'b0, vec3}) != (c - 1) / (s + 1)) vec_err++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy3, 0);
        check("rst_done", done3, 0);
        check("rst_vec", vec3, 0);
        check("rst_cap", cap3, 0);
        check("rst_mc", mc3, 0);
        check("rst_ffv", ffv3, 0);
        check("rst_pass", pass3, 0);
        rst_n = 1;

        sweep(0, 0);
        check("maj_done_cyc", done_at, 17);
        check("maj_ndone", ndone, 1);
        check("maj_vec_seq", vec_err, 0);
        check("maj_pass", pass3, 1);
        check("maj_mc", mc3, 0);
        check("maj_cap", cap3, 8'hE8);
        check("maj_ffv", ffv3, 0);
        check("maj_busy_after", busy3, 0);
        check("maj_vec_hold", vec3, 7);

        inv3 = 1;
        sweep(0, 0);
        check("inv_pass", pass3, 0);
        check("inv_mc", mc3, 8);
        check("inv_cap", cap3, 8'h17);
        check("inv_ffi", ffi3, 0);
        check("inv_ffv", ffv3, 1);

        sweep(1, 0);
        check("n4_done_cyc", done_at, 17);
        check("n4_vec_seq", vec_err, 0);
        check("n4_mc", mc4, 2);
        check("n4_ffi", ffi4, 5);
        check("n4_ffv", ffv4, 1);
        check("n4_cap", cap4, 16'h1020);
        check("n4_pass", pass4, 0);

        @(negedge clk) start3 = 1;
        @(negedge clk) start3 = 0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", busy3, 1);
        check("pre_rst_mc", mc3, 2);
        check("pre_rst_cap", cap3, 8'h03);
        rst_n = 0;
        #1;
        check("mid_rst_busy", busy3, 0);
        check("mid_rst_vec", vec3, 0);
        check("mid_rst_mc", mc3, 0);
        check("mid_rst_cap", cap3, 0);
        check("mid_rst_ffv", ffv3, 0);
        check("mid_rst_done", done3, 0);
        @(negedge clk) rst_n = 1;
        inv3 = 0;
        sweep(0, 0);
        check("post_rst_done_cyc", done_at, 17);
        check("post_rst_cap", cap3, 8'hE8);
        check("post_rst_pass", pass3, 1);

        sweep(0, 4);
        check("restart_ndone", ndone, 1);
        check("restart_done_cyc", done_at, 17);
        check("restart_vec_seq", vec_err, 0);
        check("restart_cap", cap3, 8'hE8);

`ifdef TT_SWEEP_ABORT_EN
        inv3 = 1;
        @(negedge clk) start3 = 1;
        @(negedge clk) start3 = 0;
        repeat (6) @(negedge clk);
        abort3 = 1;
        @(negedge clk) abort3 = 0;
        check("abort_busy", busy3, 0);
        check("abort_flag", aborted3, 1);
        check("abort_cap", cap3, 8'h07);
        check("abort_mc", mc3, 3);
        check("abort_pass", pass3, 0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done3) ndone++;
        end
        check("abort_no_done", ndone, 0);
        @(negedge clk) start3 = 1;
        @(negedge clk) start3 = 0;
        check("abort_clear", aborted3, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
